load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/lsu_lane_align.sv | 41 ++++
 rtl/load_store_unit.sv | 123 ++++++++++++
 tb/tb_load_store_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, data width.
// Also holds the alignment check used at request acceptance.
package lsu_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    // Illegal size, or an access not naturally aligned to its size.
    function automatic logic req_is_err(input logic [1:0] size, input logic [1:0] offset);
        return (size == SIZE_ILL) ||
               ((size == SIZE_HALF) && offset[0]) ||
               ((size == SIZE_WORD) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane steering for the LSU: extracts and extends load data, merges store data into a word.
// Purely combinational.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]        size,
    input  logic [1:0]        offset,
    input  logic              is_unsigned,
    input  logic [DATA_W-1:0] mem_word,
    input  logic [DATA_W-1:0] st_data,
    output logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = mem_word[{offset, 3'b000} +: 8];
        half_sel = mem_word[{offset[1], 4'b0000} +: 16];
        ld_data  = mem_word;
        merged   = st_data;
        case (size)
            SIZE_BYTE: begin
                ld_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
                merged  = mem_word;
                merged[{offset, 3'b000} +: 8] = st_data[7:0];
            end
            SIZE_HALF: begin
                ld_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
                merged  = mem_word;
                merged[{offset[1], 4'b0000} +: 16] = st_data[15:0];
            end
            default: begin
                ld_data = mem_word;
                merged  = st_data;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding request, sub-word stores done as read-modify-write.
// Latency: error 1, load/word store 2, byte/half store 3 cycles after acceptance.
// Backpressure: req_ready only in IDLE; responses are a single unstalled pulse.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_error,
    output logic              MemWrite,
    output logic              MemRead,
    output logic [31:0]       mem_address,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);

    lsu_state_e        state_q, state_d;
    logic [1:0]        size_q, size_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              unsigned_q, unsigned_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] buf_q, buf_d;

    logic              accept;
    logic              req_err;
    logic [DATA_W-1:0] ld_word;
    logic [DATA_W-1:0] st_word;

    assign accept  = (state_q == IDLE) && req_valid;
    assign req_err = req_is_err(req_size, req_addr[1:0]);

    lsu_lane_align u_align (
        .size        (size_q),
        .offset      (addr_q[1:0]),
        .is_unsigned (unsigned_q),
        .mem_word    (buf_q),
        .st_data     (wdata_q),
        .ld_data     (ld_word),
        .merged      (st_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            size_q     <= 2'b00;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            err_q      <= 1'b0;
            buf_q      <= '0;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            write_q    <= write_d;
            unsigned_q <= unsigned_d;
            err_q      <= err_d;
            buf_q      <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)
                        state_d = RESP;
                    else if (req_write && (req_size == SIZE_WORD))
                        state_d = WRITE;
                    else
                        state_d = READ;
                end
            end
            // Stores only pass through READ when they need the old word to merge into.
            READ:    state_d = write_q ? WRITE : RESP;
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        size_d     = accept ? req_size     : size_q;
        addr_d     = accept ? req_addr     : addr_q;
        wdata_d    = accept ? req_wdata    : wdata_q;
        write_d    = accept ? req_write    : write_q;
        unsigned_d = accept ? req_unsigned : unsigned_q;
        err_d      = accept ? req_err      : err_q;
        buf_d      = (state_q == READ) ? mem_read_data : buf_q;
    end

    always_comb begin
        req_ready      = (state_q == IDLE);
        MemRead        = (state_q == READ);
        MemWrite       = (state_q == WRITE);
        mem_address    = 32'd0;
        mem_write_data = 32'd0;
        resp_valid     = (state_q == RESP);
        resp_error     = (state_q == RESP) && err_q;
        resp_rdata     = 32'd0;
        if ((state_q == READ) || (state_q == WRITE))
            mem_address = {addr_q[31:2], 2'b00};
        if (state_q == WRITE)
            mem_write_data = st_word;
        if ((state_q == RESP) && !write_q && !err_q)
            resp_rdata = ld_word;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word-addressed data memory.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_error;
    logic [31:0] resp_rdata;
    logic        MemWrite, MemRead;
    logic [31:0] mem_address, mem_write_data, mem_read_data;

    logic [31:0] mem [0:15];
    logic        tb_we;
    logic [3:0]  tb_idx;
    logic [31:0] tb_dat;
    logic [31:0] last_wr_addr, last_wr_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_error     (resp_error),
        .MemWrite       (MemWrite),
        .MemRead        (MemRead),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    assign mem_read_data = mem[mem_address[5:2]];

    always @(posedge clk) begin
        if (MemWrite) begin
            mem[mem_address[5:2]] <= mem_write_data;
            last_wr_addr          <= mem_address;
            last_wr_data          <= mem_write_data;
        end else if (tb_we) begin
            mem[tb_idx] <= tb_dat;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [3:0] idx, input logic [31:0] dat);
        @(negedge clk);
        tb_we = 1'b1; tb_idx = idx; tb_dat = dat;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic set_req(input logic w, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] wd);
        req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
    endtask

    // Issue one request, then measure latency and strobe activity until its response.
    task automatic do_req(input string tag, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int exp_lat, input logic [31:0] exp_rd, input logic exp_err,
                          input int exp_nrd, input int exp_nwr);
        int lat, nrd, nwr;
        logic [31:0] rd;
        logic er;
        lat = 0; nrd = 0; nwr = 0; rd = 32'hx; er = 1'bx;
        @(negedge clk);
        set_req(w, sz, u, a, wd);
        req_valid = 1'b1;
        check_val({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            if (MemRead)  nrd++;
            if (MemWrite) nwr++;
            if (resp_valid) begin
                lat = c; rd = resp_rdata; er = resp_error;
            end else begin
                @(negedge clk);
            end
        end
        check_val({tag, "_lat"},   lat,         exp_lat);
        check_val({tag, "_rdata"}, rd,          exp_rd);
        check_val({tag, "_err"},   {31'd0, er}, {31'd0, exp_err});
        check_val({tag, "_nrd"},   nrd,         exp_nrd);
        check_val({tag, "_nwr"},   nwr,         exp_nwr);
        @(negedge clk);
        check_val({tag, "_pulse"}, {31'd0, resp_valid}, 32'd0);
        check_val({tag, "_idle"},  {31'd0, req_ready},  32'd1);
    endtask

    logic [31:0] b2b_addr [0:2];
    logic [31:0] b2b_exp  [0:2];
    int acc, nresp;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; tb_we = 1'b0; tb_idx = 4'd0; tb_dat = 32'd0;
        set_req(1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        check_val("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_val("rst_memwrite",   {31'd0, MemWrite},   32'd0);
        check_val("rst_memread",    {31'd0, MemRead},    32'd0);
        check_val("rst_rdata",      resp_rdata,          32'd0);
        check_val("rst_mem_addr",   mem_address,         32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_ready", {31'd0, req_ready}, 32'd1);

        // Word store then word load.
        do_req("st_w", 1'b1, 2'b10, 1'b0, 32'h4, 32'hDEADBEEF, 2, 32'd0, 1'b0, 0, 1);
        check_val("st_w_addr", last_wr_addr, 32'h4);
        check_val("st_w_data", last_wr_data, 32'hDEADBEEF);
        do_req("ld_w", 1'b0, 2'b10, 1'b0, 32'h4, 32'd0, 2, 32'hDEADBEEF, 1'b0, 1, 0);

        // Byte and halfword loads with sign/zero extension.
        poke(4'd2, 32'h80FF7F01);
        do_req("ld_b_b_s", 1'b0, 2'b00, 1'b0, 32'hB, 32'd0, 2, 32'hFFFFFF80, 1'b0, 1, 0);
        do_req("ld_b_b_u", 1'b0, 2'b00, 1'b1, 32'hB, 32'd0, 2, 32'h00000080, 1'b0, 1, 0);
        do_req("ld_b_9_s", 1'b0, 2'b00, 1'b0, 32'h9, 32'd0, 2, 32'h0000007F, 1'b0, 1, 0);
        do_req("ld_b_8_s", 1'b0, 2'b00, 1'b0, 32'h8, 32'd0, 2, 32'h00000001, 1'b0, 1, 0);
        do_req("ld_b_a_s", 1'b0, 2'b00, 1'b0, 32'hA, 32'd0, 2, 32'hFFFFFFFF, 1'b0, 1, 0);
        do_req("ld_h_a_s", 1'b0, 2'b01, 1'b0, 32'hA, 32'd0, 2, 32'hFFFF80FF, 1'b0, 1, 0);
        do_req("ld_h_8_u", 1'b0, 2'b01, 1'b1, 32'h8, 32'd0, 2, 32'h00007F01, 1'b0, 1, 0);

        // Sub-word store goes through read-modify-write.
        do_req("st_b", 1'b1, 2'b00, 1'b0, 32'h5, 32'h00000012, 3, 32'd0, 1'b0, 1, 1);
        check_val("st_b_addr", last_wr_addr, 32'h4);
        check_val("st_b_data", last_wr_data, 32'hDEAD12EF);
        check_val("st_b_mem",  mem[1],       32'hDEAD12EF);

        // Misaligned and illegal-size requests.
        do_req("err_h3",  1'b0, 2'b01, 1'b0, 32'h3, 32'd0,      1, 32'd0, 1'b1, 0, 0);
        do_req("err_w6",  1'b1, 2'b10, 1'b0, 32'h6, 32'h12345678, 1, 32'd0, 1'b1, 0, 0);
        do_req("err_s11", 1'b0, 2'b11, 1'b0, 32'h8, 32'd0,      1, 32'd0, 1'b1, 0, 0);
        check_val("err_mem1", mem[1], 32'hDEAD12EF);

        // Reset asserted while a halfword store sits in WRITE.
        poke(4'd3, 32'h11223344);
        @(negedge clk);
        set_req(1'b1, 2'b01, 1'b0, 32'hE, 32'h0000AAAA);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check_val("rstw_in_read", {31'd0, MemRead}, 32'd1);
        @(negedge clk);
        check_val("rstw_in_write", {31'd0, MemWrite}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("rstw_wr_drop", {31'd0, MemWrite}, 32'd0);
        @(negedge clk);
        check_val("rstw_no_resp", {31'd0, resp_valid}, 32'd0);
        check_val("rstw_mem",     mem[3],              32'h11223344);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rstw_ready",    {31'd0, req_ready},  32'd1);
        check_val("rstw_no_resp2", {31'd0, resp_valid}, 32'd0);
        check_val("rstw_mem2",     mem[3],              32'h11223344);

        // Three loads with req_valid held high throughout.
        b2b_addr[0] = 32'h4; b2b_exp[0] = 32'hDEAD12EF;
        b2b_addr[1] = 32'h8; b2b_exp[1] = 32'h80FF7F01;
        b2b_addr[2] = 32'hC; b2b_exp[2] = 32'h11223344;
        acc = 0; nresp = 0;
        for (int c = 0; c < 40 && nresp < 3; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                if (nresp < 3) check_val("b2b_rdata", resp_rdata, b2b_exp[nresp]);
                nresp++;
            end
            if (acc < 3) begin
                set_req(1'b0, 2'b10, 1'b0, b2b_addr[acc], 32'd0);
                req_valid = 1'b1;
            end else begin
                req_valid = 1'b0;
            end
            if (req_valid && req_ready) acc++;
        end
        req_valid = 1'b0;
        check_val("b2b_accepts", acc,   32'd3);
        check_val("b2b_resps",   nresp, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
